// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall and branch flush control for a 5-stage pipeline.
// Define HAZARD_STATS_EN to add saturating stall/flush statistics counters.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic              load_d,
    input  logic              pc_src_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
`ifdef HAZARD_STATS_EN
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`else
    output logic              flush_e
`endif
);
    logic [REG_AW-1:0] e_rs1, e_rs2, e_rd, m_rd, w_rd;
    logic              e_rw, e_ld, m_rw, w_rw, lw_stall;

    // register 0 is hardwired, so a write to it must never be forwarded
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, md, wd, input logic mw, ww);
        return (mw && md != '0 && md == rs) ? 2'b10 :
               (ww && wd != '0 && wd == rs) ? 2'b01 : 2'b00;
    endfunction

    always_comb begin
        lw_stall = e_ld && e_rd != '0 && (e_rd == rs1_d || e_rd == rs2_d);
        fwd_a_e  = fwd_sel(e_rs1, m_rd, w_rd, m_rw, w_rw);
        fwd_b_e  = fwd_sel(e_rs2, m_rd, w_rd, m_rw, w_rw);
        stall_f  = lw_stall;
        stall_d  = lw_stall;
        flush_d  = pc_src_e;
        flush_e  = lw_stall || pc_src_e;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {e_rs1, e_rs2, e_rd, e_rw, e_ld} <= '0;
            {m_rd, m_rw, w_rd, w_rw}         <= '0;
        end else begin
            {e_rs1, e_rs2, e_rd, e_rw, e_ld} <= flush_e ? '0 : {rs1_d, rs2_d, rd_d, reg_write_d, load_d};
            {m_rd, m_rw}                     <= {e_rd, e_rw};
            {w_rd, w_rw}                     <= {m_rd, m_rw};
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lw_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (pc_src_e && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-003 The block SHALL have input clk, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit: asynchronous, active-high.
REQ-005 The block SHALL have inputs rs1_d and rs2_d, each REG_AW bits: decode-stage source registers.
REQ-006 The block SHALL have input rd_d, REG_AW bits: decode-stage destination register.
REQ-007 The block SHALL have input reg_write_d, 1 bit: the decode-stage instruction writes rd_d.
REQ-008 The block SHALL have input load_d, 1 bit: the decode-stage instruction is a load.
REQ-009 The block SHALL have input pc_src_e, 1 bit: a branch or jump is taken in execute.
REQ-010 The block SHALL have outputs fwd_a_e and fwd_b_e, 2 bits each: execute operand mux selects (00 register file, 01 writeback result, 10 memory-stage ALU result).
REQ-011 The block SHALL have outputs stall_f and stall_d, 1 bit each: hold the fetch and decode registers.
REQ-012 The block SHALL have outputs flush_d and flush_e, 1 bit each: clear the decode and execute registers.
REQ-013 The block SHALL have outputs stall_cnt and flush_cnt, CNT_W bits each, present only with HAZARD_STATS_EN.

Function
REQ-014 The block SHALL hold shadow stages E (rs1, rs2, rd, reg_write, load), M (rd, reg_write) and W (rd, reg_write), advanced every clock: E<=D inputs, M<=E, W<=M.
REQ-015 The block SHALL load a bubble into E (all fields zero) in any cycle where flush_e=1, instead of the D inputs.
REQ-016 The block SHALL drive fwd_a_e=10 when M.reg_write=1, M.rd!=0 and M.rd==E.rs1; else 01 when W.reg_write=1, W.rd!=0 and W.rd==E.rs1; else 00.
REQ-017 The block SHALL compute fwd_b_e identically using E.rs2, and SHALL never forward for register 0; the M match takes priority over the W match.
REQ-018 The block SHALL compute lw_stall = E.load & (E.rd!=0) & (E.rd==rs1_d | E.rd==rs2_d), combinationally.
REQ-019 The block SHALL drive stall_f=stall_d=lw_stall, flush_d=pc_src_e and flush_e=lw_stall|pc_src_e.
REQ-020 When lw_stall and pc_src_e are both 1, the block SHALL assert all four controls; the flush takes precedence downstream.
REQ-021 The block SHALL produce a load-use stall of exactly one cycle: after the bubble enters E, lw_stall deasserts and the dependency resolves through the W-stage forward (fwd=01) two cycles later.
REQ-022 All select and control outputs SHALL be combinational from the shadow state and current inputs, with zero-cycle latency.

Reset
REQ-023 Asserting reset SHALL immediately clear all shadow stages to bubbles, which forces fwd_a_e=fwd_b_e=00 and stall_f=stall_d=0 while reset is held.
REQ-024 Asserting reset SHALL immediately clear the statistics counters to 0.
REQ-025 Reset asserted mid-stall SHALL cancel the stall; the first post-reset cycle SHALL reflect only the current inputs.

Configuration
REQ-026 With macro HAZARD_STATS_EN defined, the block SHALL maintain stall_cnt, incrementing on each cycle with lw_stall=1.
REQ-027 With macro HAZARD_STATS_EN defined, the block SHALL maintain flush_cnt, incrementing on each cycle with pc_src_e=1.
REQ-028 Both statistics counters SHALL saturate at 2^CNT_W-1.
REQ-029 Without HAZARD_STATS_EN, the block SHALL omit the counter ports and logic; all other behaviour SHALL be identical.

Verification
REQ-030 Back-to-back ALU ops (add x5 followed by a use of x5 as rs1) -> in the user's E cycle fwd_a_e=10; with one independent instruction between them -> fwd_a_e=01.
REQ-031 M and W both write x7 and E.rs2=7 -> fwd_b_e=10 (M priority); a write of x0 matching E.rs1=0 -> fwd_a_e=00.
REQ-032 Load of x3 followed by a use of x3 as rs2 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle, then fwd_b_e=01 on the user's E cycle.
REQ-033 pc_src_e=1 for one cycle -> flush_d=flush_e=1 in that cycle, and E holds a bubble in the next cycle (no forwarding from it).
REQ-034 Reset pulse during a load-use stall -> stall outputs deassert immediately; with HAZARD_STATS_EN, the counters read 0.
REQ-035 With HAZARD_STATS_EN and CNT_W=4, 20 stall cycles -> stall_cnt=15 (saturated).
